// File: rtl/data_mem_hs.sv
// Handshaked local data RAM for the load/store path: one outstanding request,
// programmable wait states, and an error response for illegal/misaligned/out-of-range accesses.
module data_mem_hs #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int         NB        = DATA_WIDTH / 8;
    localparam int         LB        = $clog2(NB);
    localparam int         IW        = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'(NB);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [IW-1:0]         idx_q;
    logic [LB-1:0]         lane_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] off;
    logic                  f3_ok, align_ok, range_ok, fault;
    logic                  accept, access;

    assign off      = req_addr - BASE_ADDR;
    assign range_ok = 64'(off) < MEM_BYTES;
    assign fault    = !(f3_ok && align_ok && range_ok);
    assign accept   = req_valid && (state == IDLE);
    assign access   = (state == BUSY) && (cnt == '0);

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            3'b011:                 f3_ok = (DATA_WIDTH == 64);
            3'b110:                 f3_ok = !req_we && (DATA_WIDTH == 64);
            default:                f3_ok = 1'b0;
        endcase
        align_ok = 1'b1;
        case (req_funct3[1:0])
            2'd0:    align_ok = 1'b1;
            2'd1:    align_ok = !off[0];
            2'd2:    align_ok = (off[1:0] == 2'b00);
            default: align_ok = (off[2:0] == 3'b000);
        endcase
    end

    // Load path: lane-align the addressed word, then size and extend.
    logic [DATA_WIDTH-1:0] word, shifted, ld_data;
    always_comb begin
        word    = mem[idx_q];
        shifted = word >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = DATA_WIDTH'($signed(shifted[7:0]));
            3'b001:  ld_data = DATA_WIDTH'($signed(shifted[15:0]));
            3'b010:  ld_data = DATA_WIDTH'($signed(shifted[31:0]));
            3'b100:  ld_data = DATA_WIDTH'(shifted[7:0]);
            3'b101:  ld_data = DATA_WIDTH'(shifted[15:0]);
            3'b110:  ld_data = DATA_WIDTH'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wsh;
    always_comb begin
        case (f3_q[1:0])
            2'd0:    be = NB'(1);
            2'd1:    be = NB'(3);
            2'd2:    be = NB'(15);
            default: be = NB'(255);
        endcase
        be  = be << lane_q;
        wsh = wdata_q << {lane_q, 3'b000};
    end

    // RAM is deliberately not reset; writes only happen on the BUSY access edge.
    always_ff @(posedge clk) begin
        if (access && we_q) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= wsh[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_d = fault ? RESP : BUSY;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            BUSY: begin
                if (cnt != '0) cnt_d = cnt - 4'd1;
                else           state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            idx_q     <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                idx_q   <= off[LB +: IW];
                lane_q  <= off[LB-1:0];
                wdata_q <= req_wdata;
                if (fault) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (access) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= we_q ? '0 : ld_data;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: three instances (RV32/1 wait, RV64/0 wait, RV32/3 wait)
// share request buses; each has its own valid and reset.
module tb_data_mem_hs;
    logic        clk = 1'b0;
    logic [2:0]  rst_n, req_valid, req_ready, rsp_valid, rsp_err;
    logic        req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rdata_a, rdata_c;
    logic [63:0] rdata_b;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    data_mem_hs #(.DATA_WIDTH(32), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(rsp_err[0]));
    data_mem_hs #(.DATA_WIDTH(64), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(rsp_err[1]));
    data_mem_hs #(.DATA_WIDTH(32), .WAIT_CYCLES(3)) u_c (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_c), .rsp_err(rsp_err[2]));

    typedef struct {
        int          s;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vt[$];

    function automatic logic [63:0] get_rd(input int s);
        case (s)
            0:       return {32'h0, rdata_a};
            1:       return rdata_b;
            default: return {32'h0, rdata_c};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic add(input int s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input logic err, input int lat);
        vec_t v;
        v.s = s; v.we = we; v.f3 = f3; v.addr = a; v.wd = wd; v.rd = rd; v.err = err; v.lat = lat;
        vt.push_back(v);
    endtask

    // lat = edges after the accept edge until rsp_valid is seen; 0 means RESP entered on the accept edge.
    task automatic do_req(input int s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, input int hold,
                          output logic [63:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid[s] = 1'b1;
        n = 0;
        while (!req_ready[s] && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[s] = 1'b0;
        lat = 0;
        while (!rsp_valid[s] && lat < 40) begin @(negedge clk); lat++; end
        rd = get_rd(s);
        er = rsp_err[s];
        if (hold > 0) begin
            // a stray store offered while busy must be ignored
            req_we = 1'b1; req_funct3 = 3'b010; req_addr = a; req_wdata = '0; req_valid[s] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("bp rsp_valid", rsp_valid[s], 1'b1);
                chk("bp rsp_rdata", get_rd(s), rd);
                chk("bp rsp_err", rsp_err[s], er);
                chk("bp req_ready", req_ready[s], 1'b0);
            end
            req_valid[s] = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (hold > 0) begin
            chk("bp done rsp_valid", rsp_valid[s], 1'b0);
            chk("bp done req_ready", req_ready[s], 1'b1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat, n;

        rst_n = '0; req_valid = '0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        // DUT A: RV32, 1 wait state -> non-faulting lat 2
        add(0, 1, 3'b010, 32'h10,  64'hDEADBEEF, 64'h0,        0, 2);
        add(0, 0, 3'b000, 32'h13,  64'h0, 64'hFFFFFFDE,        0, 2);
        add(0, 0, 3'b100, 32'h13,  64'h0, 64'h000000DE,        0, 2);
        add(0, 0, 3'b101, 32'h12,  64'h0, 64'h0000DEAD,        0, 2);
        add(0, 0, 3'b001, 32'h10,  64'h0, 64'hFFFFBEEF,        0, 2);
        // byte 0x11 holds 0xBE, so it is the one replaced
        add(0, 1, 3'b000, 32'h11,  64'h5A, 64'h0,              0, 2);
        add(0, 0, 3'b010, 32'h10,  64'h0, 64'hDEAD5AEF,        0, 2);
        add(0, 0, 3'b010, 32'h12,  64'h0, 64'h0,               1, 0);
        add(0, 1, 3'b010, 32'h3FC, 64'h11223344, 64'h0,        0, 2);
        add(0, 1, 3'b001, 32'h401, 64'hBEEF, 64'h0,            1, 0);
        add(0, 0, 3'b010, 32'h3FC, 64'h0, 64'h11223344,        0, 2);
        add(0, 0, 3'b010, 32'h400, 64'h0, 64'h0,               1, 0);
        add(0, 1, 3'b010, 32'h11,  64'hFFFFFFFF, 64'h0,        1, 0);
        add(0, 0, 3'b011, 32'h10,  64'h0, 64'h0,               1, 0);
        add(0, 1, 3'b011, 32'h10,  64'hFFFFFFFF, 64'h0,        1, 0);
        add(0, 0, 3'b110, 32'h10,  64'h0, 64'h0,               1, 0);
        add(0, 0, 3'b111, 32'h10,  64'h0, 64'h0,               1, 0);
        add(0, 1, 3'b100, 32'h10,  64'hFF, 64'h0,              1, 0);
        add(0, 0, 3'b101, 32'h11,  64'h0, 64'h0,               1, 0);
        add(0, 0, 3'b010, 32'h10,  64'h0, 64'hDEAD5AEF,        0, 2);
        add(0, 1, 3'b001, 32'h12,  64'hCAFE, 64'h0,            0, 2);
        add(0, 0, 3'b010, 32'h10,  64'h0, 64'hCAFE5AEF,        0, 2);
        // DUT B: RV64, no wait states -> non-faulting lat 1
        add(1, 1, 3'b011, 32'h8,   64'h8000000012345678, 64'h0, 0, 1);
        add(1, 0, 3'b110, 32'hC,   64'h0, 64'h0000000080000000, 0, 1);
        add(1, 0, 3'b010, 32'hC,   64'h0, 64'hFFFFFFFF80000000, 0, 1);
        add(1, 0, 3'b011, 32'h8,   64'h0, 64'h8000000012345678, 0, 1);
        add(1, 0, 3'b000, 32'hF,   64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1);
        add(1, 0, 3'b101, 32'hA,   64'h0, 64'h0000000000001234, 0, 1);
        add(1, 0, 3'b011, 32'hC,   64'h0, 64'h0,                1, 0);
        add(1, 1, 3'b011, 32'h800, 64'h1, 64'h0,                1, 0);
        add(1, 1, 3'b010, 32'hC,   64'hCAFEBABE, 64'h0,         0, 1);
        add(1, 0, 3'b011, 32'h8,   64'h0, 64'hCAFEBABE12345678, 0, 1);
        // DUT C: RV32, 3 wait states -> non-faulting lat 4
        add(2, 1, 3'b010, 32'h20,  64'hAAAAAAAA, 64'h0,         0, 4);
        add(2, 0, 3'b010, 32'h20,  64'h0, 64'hAAAAAAAA,         0, 4);

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst%0d req_ready", s), req_ready[s], 1'b1);
            chk($sformatf("rst%0d rsp_valid", s), rsp_valid[s], 1'b0);
            chk($sformatf("rst%0d rsp_err", s), rsp_err[s], 1'b0);
            chk($sformatf("rst%0d rsp_rdata", s), get_rd(s), 64'h0);
        end
        rst_n = 3'b111;

        foreach (vt[i]) begin
            do_req(vt[i].s, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, 0, rd, er, lat);
            chk($sformatf("v%0d rdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d err", i), er, vt[i].err);
            chk($sformatf("v%0d latency", i), lat, vt[i].lat);
        end

        // backpressure on A, then confirm the stray store was not taken
        do_req(0, 0, 3'b010, 32'h10, 64'h0, 5, rd, er, lat);
        chk("bp rdata", rd, 64'hCAFE5AEF);
        chk("bp latency", lat, 2);
        do_req(0, 0, 3'b010, 32'h10, 64'h0, 0, rd, er, lat);
        chk("post-bp rdata", rd, 64'hCAFE5AEF);

        // reset C while BUSY on a store: store must be dropped
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 64'h11111111;
        req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        chk("busy req_ready", req_ready[2], 1'b0);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("busy-rst rsp_valid", rsp_valid[2], 1'b0);
        chk("busy-rst req_ready", req_ready[2], 1'b1);
        @(negedge clk);
        rst_n[2] = 1'b1;
        do_req(2, 0, 3'b010, 32'h20, 64'h0, 0, rd, er, lat);
        chk("after busy-rst rdata", rd, 64'hAAAAAAAA);

        // reset C while holding a response: rsp_valid and rsp_rdata drop at once
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        n = 0;
        while (!rsp_valid[2] && n < 40) begin @(negedge clk); n++; end
        chk("resp-rst pre valid", rsp_valid[2], 1'b1);
        chk("resp-rst pre rdata", get_rd(2), 64'hAAAAAAAA);
        rst_n[2] = 1'b0;
        #1;
        chk("resp-rst rsp_valid", rsp_valid[2], 1'b0);
        chk("resp-rst rsp_rdata", get_rd(2), 64'h0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        do_req(2, 0, 3'b100, 32'h21, 64'h0, 0, rd, er, lat);
        chk("after resp-rst rdata", rd, 64'h000000AA);
        chk("after resp-rst latency", lat, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
